// File: rtl/dist_uart_pkg.sv
// Shared types, ASCII constants and helpers for the distance UART framer.
// Define DIST_FRAME_CHECKSUM_EN to append '*' plus a two-digit hex XOR checksum.
package dist_uart_pkg;

    typedef enum logic [2:0] {StIdle, StLoad, StSend, StWait, StGap} state_e;

    typedef struct packed {
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] units;
        logic       out_of_range;
    } snapshot_t;

    localparam logic [7:0] AsciiZero  = 8'h30;
    localparam logic [7:0] AsciiSpace = 8'h20;
    localparam logic [7:0] AsciiLowC  = 8'h63;
    localparam logic [7:0] AsciiLowM  = 8'h6D;
    localparam logic [7:0] AsciiCr    = 8'h0D;
    localparam logic [7:0] AsciiLf    = 8'h0A;
    localparam logic [7:0] AsciiDash  = 8'h2D;
    localparam logic [7:0] AsciiQmark = 8'h3F;
    localparam logic [7:0] AsciiStar  = 8'h2A;

`ifdef DIST_FRAME_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = 11;
`else
    localparam int unsigned FRAME_LEN = 8;
`endif

    // 0x37 = 'A' - 10, giving uppercase hex letters.
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        return (nib <= 4'd9) ? (AsciiZero + {4'd0, nib}) : (8'h37 + {4'd0, nib});
    endfunction

    function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit, input logic oor);
        if (oor) begin
            return AsciiDash;
        end
        return (digit <= 4'd9) ? (AsciiZero + {4'd0, digit}) : AsciiQmark;
    endfunction

endpackage

// File: rtl/uart_byte_serializer.sv
// 8N1 byte serialiser with internal baud divider; done marks the last cycle of the stop bit.
module uart_byte_serializer #(
    parameter int unsigned BAUD_DIV = 625
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(BAUD_DIV);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            bit_end;

    assign bit_end = (cnt_q == CntW'(BAUD_DIV - 1));

    // bit_q: 0 = start, 1..8 = data LSB first, 9 = stop.
    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done    = busy_q && bit_end && (bit_q == 4'd9);
        if (!busy_q) begin
            if (start) begin
                busy_d  = 1'b1;
                tx_d    = 1'b0;
                shift_d = data;
                bit_d   = 4'd0;
                cnt_d   = '0;
            end
        end else if (!bit_end) begin
            cnt_d = cnt_q + CntW'(1);
        end else begin
            cnt_d = '0;
            if (bit_q == 4'd9) begin
                busy_d = 1'b0;
                tx_d   = 1'b1;
            end else begin
                bit_d = bit_q + 4'd1;
                if (bit_q == 4'd8) begin
                    tx_d = 1'b1;
                end else begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: rtl/distance_uart_framer.sv
// Formats BCD distance snapshots into "DDD cm\r\n" frames and sends them as 8N1 UART.
// Optional DIST_FRAME_CHECKSUM_EN adds "*HH" (XOR of bytes 0..5) before CR LF.
module distance_uart_framer
    import dist_uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 625,
    parameter logic [23:0] GAP_CYCLES = 24'd6000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       digit_valid,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    input  logic       out_of_range,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic       dropped
);

    localparam logic [3:0] LastIdx = 4'(FRAME_LEN - 1);

    state_e     state_q, state_d;
    snapshot_t  pend_q, pend_d;
    snapshot_t  frame_q, frame_d;
    logic       pend_full_q, pend_full_d;
    logic [3:0] idx_q, idx_d;
    logic [23:0] gap_q, gap_d;
    logic       frame_done_q, frame_done_d;
    logic       dropped_q, dropped_d;

    logic       ser_start, ser_done, ser_busy;
    logic [7:0] cur_byte;
    logic [7:0] d2, d1, d0;
    logic       gap_expire;

    assign d2 = digit_to_ascii(frame_q.hundreds, frame_q.out_of_range);
    assign d1 = digit_to_ascii(frame_q.tens, frame_q.out_of_range);
    assign d0 = digit_to_ascii(frame_q.units, frame_q.out_of_range);

`ifdef DIST_FRAME_CHECKSUM_EN
    logic [7:0] csum;
    assign csum = d2 ^ d1 ^ d0 ^ AsciiSpace ^ AsciiLowC ^ AsciiLowM;
`endif

    always_comb begin
        cur_byte = AsciiSpace;
        case (idx_q)
            4'd0:    cur_byte = d2;
            4'd1:    cur_byte = d1;
            4'd2:    cur_byte = d0;
            4'd3:    cur_byte = AsciiSpace;
            4'd4:    cur_byte = AsciiLowC;
            4'd5:    cur_byte = AsciiLowM;
`ifdef DIST_FRAME_CHECKSUM_EN
            4'd6:    cur_byte = AsciiStar;
            4'd7:    cur_byte = hex_to_ascii(csum[7:4]);
            4'd8:    cur_byte = hex_to_ascii(csum[3:0]);
            4'd9:    cur_byte = AsciiCr;
            4'd10:   cur_byte = AsciiLf;
`else
            4'd6:    cur_byte = AsciiCr;
            4'd7:    cur_byte = AsciiLf;
`endif
            default: cur_byte = AsciiSpace;
        endcase
    end

    // Widened compare so GAP_CYCLES = 0 exits after a single GAP cycle.
    assign gap_expire = ({1'b0, gap_q} + 25'd1) >= {1'b0, GAP_CYCLES};

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;
        frame_d      = frame_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        frame_done_d = 1'b0;
        dropped_d    = 1'b0;
        ser_start    = 1'b0;

        if (digit_valid) begin
            pend_d      = '{hundreds: hundreds, tens: tens, units: units,
                            out_of_range: out_of_range};
            pend_full_d = 1'b1;
            // A capture coinciding with LOAD refills the slot being emptied: nothing lost.
            dropped_d   = pend_full_q && (state_q != StLoad);
        end

        case (state_q)
            StIdle: begin
                if (pend_full_q) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                frame_d = pend_q;
                if (!digit_valid) begin
                    pend_full_d = 1'b0;
                end
                idx_d   = 4'd0;
                state_d = StSend;
            end
            StSend: begin
                ser_start = !ser_busy;
                state_d   = StWait;
            end
            StWait: begin
                if (ser_done) begin
                    if (idx_q != LastIdx) begin
                        idx_d   = idx_q + 4'd1;
                        state_d = StSend;
                    end else begin
                        frame_done_d = 1'b1;
                        gap_d        = 24'd0;
                        state_d      = StGap;
                    end
                end
            end
            StGap: begin
                if (gap_expire) begin
                    gap_d   = 24'd0;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 24'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            frame_q      <= '0;
            idx_q        <= 4'd0;
            gap_q        <= 24'd0;
            frame_done_q <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            frame_q      <= frame_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            frame_done_q <= frame_done_d;
            dropped_q    <= dropped_d;
        end
    end

    uart_byte_serializer #(
        .BAUD_DIV(BAUD_DIV)
    ) u_ser (
        .clk  (clk),
        .rst  (rst),
        .start(ser_start),
        .data (cur_byte),
        .tx   (tx),
        .done (ser_done),
        .busy (ser_busy)
    );

    assign busy       = (state_q != StIdle);
    assign frame_done = frame_done_q;
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_distance_uart_framer.sv
// Self-checking bench for distance_uart_framer: UART line decoder plus a string-level frame model.
`timescale 1ns/1ps
module tb_distance_uart_framer;

    localparam int BD  = 4;
    localparam int GAP = 20;
`ifdef DIST_FRAME_CHECKSUM_EN
    localparam int FL = 11;
`else
    localparam int FL = 8;
`endif

    typedef logic [7:0] frame_t [11];
    typedef struct {
        int         h;
        int         t;
        int         u;
        bit         oor;
        logic [47:0] exp6;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] hundreds = 4'd0;
    logic [3:0] tens = 4'd0;
    logic [3:0] units = 4'd0;
    logic       out_of_range = 1'b0;
    logic       tx, busy, frame_done, dropped;

    int total = 0;
    int bad = 0;
    logic [7:0] rx_buf [1024];
    int rx_cnt = 0;
    int rd_ptr = 0;
    int fd_cnt = 0;
    int drop_cnt = 0;
    vec_t tbl [5];

    distance_uart_framer #(
        .BAUD_DIV  (BD),
        .GAP_CYCLES(24'd20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digit_valid (digit_valid),
        .hundreds    (hundreds),
        .tens        (tens),
        .units       (units),
        .out_of_range(out_of_range),
        .tx          (tx),
        .busy        (busy),
        .frame_done  (frame_done),
        .dropped     (dropped)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (dropped === 1'b1) drop_cnt++;
    end

    // Mid-bit sampling UART receiver.
    initial begin : decoder
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                repeat (BD / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BD) @(negedge clk);
                if (rx_cnt < 1024) begin
                    rx_buf[rx_cnt] = b;
                    rx_cnt++;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] hexch(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
    endfunction

    task automatic finish_frame(inout frame_t f);
        logic [7:0] cs;
        cs = 8'h00;
        for (int k = 0; k < 6; k++) cs = cs ^ f[k];
        for (int k = 6; k < 11; k++) f[k] = 8'h00;
        if (FL == 11) begin
            f[6] = "*";
            f[7] = hexch(int'(cs[7:4]));
            f[8] = hexch(int'(cs[3:0]));
            f[9] = 8'd13;
            f[10] = 8'd10;
        end else begin
            f[6] = 8'd13;
            f[7] = 8'd10;
        end
    endtask

    task automatic from_prefix(input logic [47:0] p, output frame_t f);
        for (int k = 0; k < 6; k++) f[k] = p[47 - 8 * k -: 8];
        finish_frame(f);
    endtask

    task automatic model(input int h, input int t, input int u, input bit oor, output frame_t f);
        int d [3];
        d[0] = h; d[1] = t; d[2] = u;
        for (int k = 0; k < 3; k++) f[k] = oor ? "-" : (d[k] < 10 ? 8'(48 + d[k]) : "?");
        f[3] = " "; f[4] = "c"; f[5] = "m";
        finish_frame(f);
    endtask

    // Inputs presented now, sampled at the next rising edge.
    task automatic strobe(input int h, input int t, input int u, input bit oor);
        hundreds = 4'(h); tens = 4'(t); units = 4'(u); out_of_range = oor;
        digit_valid = 1'b1;
        @(posedge clk); #1;
        digit_valid = 1'b0;
    endtask

    task automatic expect_frame(input string nm, input frame_t f);
        int n;
        n = 0;
        while (rx_cnt < rd_ptr + FL && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (rx_cnt < rd_ptr + FL) begin
            chk({nm, "_timeout"}, rx_cnt - rd_ptr, FL);
            rd_ptr = rx_cnt;
        end else begin
            for (int i = 0; i < FL; i++) chk($sformatf("%s_b%0d", nm, i), rx_buf[rd_ptr + i], f[i]);
            rd_ptr += FL;
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy !== 1'b0) chk({nm, "_idle_timeout"}, 1, 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin : main
        frame_t f, g;
        int fd0, dr0, n, hi;

        tbl[0] = '{h: 0, t: 4, u: 2, oor: 1'b0, exp6: "042 cm"};
        tbl[1] = '{h: 1, t: 2, u: 3, oor: 1'b1, exp6: "--- cm"};
        tbl[2] = '{h: 1, t: 11, u: 3, oor: 1'b0, exp6: "1?3 cm"};
        tbl[3] = '{h: 9, t: 9, u: 9, oor: 1'b0, exp6: "999 cm"};
        tbl[4] = '{h: 15, t: 0, u: 0, oor: 1'b0, exp6: "?00 cm"};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_dropped", dropped, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_tx", tx, 1);

        // Latency, frame_done, gap length.
        fd0 = fd_cnt;
        strobe(0, 4, 2, 0);
        chk("lat_busy_n0", busy, 0);
        @(posedge clk); #1; chk("lat_tx_n1", tx, 1);
        @(posedge clk); #1; chk("lat_tx_n2", tx, 1);
        @(posedge clk); #1; chk("lat_tx_n3", tx, 0);
        n = 0;
        while (frame_done !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t1_frame_done_seen", frame_done, 1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t1_gap_len", n, GAP);
        from_prefix(tbl[0].exp6, f);
        expect_frame("t1", f);
        wait_idle("t1");
        chk("t1_fd_count", fd_cnt - fd0, 1);

        for (int i = 0; i < 5; i++) begin
            strobe(tbl[i].h, tbl[i].t, tbl[i].u, tbl[i].oor);
            from_prefix(tbl[i].exp6, f);
            expect_frame($sformatf("tbl%0d", i), f);
            wait_idle("tbl");
        end

        // Latest-wins pending slot during a frame.
        dr0 = drop_cnt;
        strobe(1, 0, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        strobe(2, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("t3_no_drop_yet", drop_cnt - dr0, 0);
        strobe(3, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("t3_drop_once", drop_cnt - dr0, 1);
        model(1, 0, 0, 0, f);
        expect_frame("t3_first", f);
        model(3, 0, 0, 0, f);
        expect_frame("t3_second", f);
        wait_idle("t3");
        chk("t3_no_extra", rx_cnt - rd_ptr, 0);

        // Second strobe lands in the LOAD cycle: both frames, no drop.
        dr0 = drop_cnt;
        strobe(5, 1, 1, 0);
        @(posedge clk); #1;
        strobe(5, 2, 2, 0);
        model(5, 1, 1, 0, f);
        expect_frame("t5_a", f);
        model(5, 2, 2, 0, g);
        expect_frame("t5_b", g);
        wait_idle("t5");
        chk("t5_no_drop", drop_cnt - dr0, 0);

        // Back-to-back strobes while still IDLE: first one overwritten.
        dr0 = drop_cnt;
        strobe(6, 1, 1, 0);
        strobe(6, 2, 2, 0);
        model(6, 2, 2, 0, f);
        expect_frame("b2b", f);
        wait_idle("b2b");
        chk("b2b_drop", drop_cnt - dr0, 1);
        chk("b2b_no_extra", rx_cnt - rd_ptr, 0);

        // Reset in the middle of byte 3.
        fd0 = fd_cnt;
        strobe(5, 6, 7, 0);
        n = 0;
        while (rx_cnt < rd_ptr + 3 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        n = 0;
        while (tx !== 1'b0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t4_tx_low_before_rst", tx, 0);
        #2 rst = 1'b1;
        #1 chk("t4_tx_async_high", tx, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (tx === 1'b1) hi++;
        end
        chk("t4_tx_high_500", hi, 500);
        chk("t4_no_frame_done", fd_cnt - fd0, 0);
        chk("t4_busy", busy, 0);
        rd_ptr = rx_cnt;

        // Random snapshots against the string model.
        for (int i = 0; i < 6; i++) begin
            int h, t, u;
            bit oor;
            h = $urandom_range(0, 15);
            t = $urandom_range(0, 15);
            u = $urandom_range(0, 15);
            oor = ($urandom_range(0, 3) == 0);
            strobe(h, t, u, oor);
            model(h, t, u, oor, f);
            expect_frame($sformatf("rnd%0d", i), f);
            wait_idle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
